// File: rtl/qosc_pkg.sv
// Shared definitions for the time-multiplexed quadrature oscillator bank:
// register field codes, FSM state type and a generic saturation helper.
package qosc_pkg;

  localparam logic [2:0] F_INIT_RE  = 3'd0;
  localparam logic [2:0] F_INIT_IM  = 3'd1;
  localparam logic [2:0] F_COEFF_RE = 3'd2;
  localparam logic [2:0] F_COEFF_IM = 3'd3;
  localparam logic [2:0] F_POWER    = 3'd4;
  localparam logic [2:0] F_ACC_RE   = 3'd5;
  localparam logic [2:0] F_ACC_IM   = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamp a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/qosc_cmac.sv
// Combinational complex multiply-shift-saturate: (re + j*im) * (c_re + j*c_im),
// each part floored by 2^power_i and clamped back to W bits.
module qosc_cmac
  import qosc_pkg::*;
#(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic signed [W-1:0] re_i,
  input  logic signed [W-1:0] im_i,
  input  logic signed [W-1:0] c_re_i,
  input  logic signed [W-1:0] c_im_i,
  input  logic        [PW-1:0] power_i,
  output logic signed [W-1:0] re_o,
  output logic signed [W-1:0] im_o
);

  localparam int PRW = 2 * W + 1;

  logic signed [PRW-1:0] re_x, im_x, cre_x, cim_x;
  logic signed [PRW-1:0] p_re, p_im, s_re, s_im;

  always_comb begin
    re_x  = PRW'(re_i);
    im_x  = PRW'(im_i);
    cre_x = PRW'(c_re_i);
    cim_x = PRW'(c_im_i);
    p_re  = re_x * cre_x - im_x * cim_x;
    p_im  = re_x * cim_x + im_x * cre_x;
    // Arithmetic shift of a signed value rounds toward minus infinity.
    s_re  = p_re >>> power_i;
    s_im  = p_im >>> power_i;
    re_o  = W'(sat(64'(s_re), W));
    im_o  = W'(sat(64'(s_im), W));
  end

endmodule

// File: rtl/refclk_sync.sv
// Two-flop synchroniser for the external step clock plus rising-edge detect;
// tick_o is a single clk-cycle pulse per refclk rise.
module refclk_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic refclk_i,
  output logic tick_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], refclk_i};
      prev_q <= sync_q[1];
    end
  end

  assign tick_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/qosc_tdm_bank.sv
// Bank of NUM_CH complex oscillators sharing one complex multiplier; each
// synchronised refclk rise runs one frame stepping channels 0..NUM_CH-1 in turn.
module qosc_tdm_bank
  import qosc_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int W      = 8,
  parameter  int PW     = 4,
  localparam int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                refclk,
  input  logic                load,
  input  logic                wr_en,
  input  logic [CH_AW+2:0]    addr,
  input  logic [W-1:0]        wr_data,
  output logic [W-1:0]        rd_data,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [CH_AW-1:0]    out_sel,
  output logic signed [W-1:0] out_re,
  output logic signed [W-1:0] out_im,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  input  logic                clr_overrun
);

  logic             tick;
  logic [CH_AW-1:0] a_ch;
  logic [2:0]       a_fld;
  logic             a_ch_ok;

  logic signed [W-1:0] init_re_q  [NUM_CH];
  logic signed [W-1:0] init_im_q  [NUM_CH];
  logic signed [W-1:0] coeff_re_q [NUM_CH];
  logic signed [W-1:0] coeff_im_q [NUM_CH];
  logic [PW-1:0]       power_q    [NUM_CH];
  logic signed [W-1:0] acc_re_q   [NUM_CH];
  logic signed [W-1:0] acc_im_q   [NUM_CH];

  state_e           state_q, state_d;
  logic [CH_AW-1:0] ch_q, ch_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic [W-1:0]     rd_data_q, rd_data_d;
  logic             last_ch, upd_en;
  logic signed [W-1:0] step_re, step_im;

  assign a_ch    = addr[CH_AW+2:3];
  assign a_fld   = addr[2:0];
  assign a_ch_ok = (int'(a_ch) < NUM_CH);

  refclk_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .refclk_i (refclk),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        init_re_q[i]  <= '0;
        init_im_q[i]  <= '0;
        coeff_re_q[i] <= '0;
        coeff_im_q[i] <= '0;
        power_q[i]    <= '0;
      end
    end else if (wr_en && a_ch_ok) begin
      case (a_fld)
        F_INIT_RE:  init_re_q[a_ch]  <= wr_data;
        F_INIT_IM:  init_im_q[a_ch]  <= wr_data;
        F_COEFF_RE: coeff_re_q[a_ch] <= wr_data;
        F_COEFF_IM: coeff_im_q[a_ch] <= wr_data;
        F_POWER:    power_q[a_ch]    <= wr_data[PW-1:0];
        default: ;
      endcase
    end
  end

  qosc_cmac #(.W(W), .PW(PW)) u_cmac (
    .re_i    (acc_re_q[ch_q]),
    .im_i    (acc_im_q[ch_q]),
    .c_re_i  (coeff_re_q[ch_q]),
    .c_im_i  (coeff_im_q[ch_q]),
    .power_i (power_q[ch_q]),
    .re_o    (step_re),
    .im_o    (step_im)
  );

  // load has priority over everything: it aborts a frame and drops ticks.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    upd_en       = 1'b0;
    last_ch      = (ch_q == CH_AW'(NUM_CH - 1));
    if (clr_overrun) overrun_d = 1'b0;
    if (load) begin
      state_d = IDLE;
      ch_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d = RUN;
            ch_d    = '0;
          end
        end
        RUN: begin
          upd_en = ch_en[ch_q];
          if (tick) overrun_d = 1'b1;
          if (last_ch) begin
            state_d      = IDLE;
            ch_d         = '0;
            frame_done_d = 1'b1;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      rd_data_q    <= rd_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_re_q[i] <= '0;
        acc_im_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_re_q[i] <= init_re_q[i];
        acc_im_q[i] <= init_im_q[i];
      end
    end else if (upd_en) begin
      acc_re_q[ch_q] <= step_re;
      acc_im_q[ch_q] <= step_im;
    end
  end

  // Readback samples the pre-write register contents.
  always_comb begin
    rd_data_d = '0;
    if (a_ch_ok) begin
      case (a_fld)
        F_INIT_RE:  rd_data_d = init_re_q[a_ch];
        F_INIT_IM:  rd_data_d = init_im_q[a_ch];
        F_COEFF_RE: rd_data_d = coeff_re_q[a_ch];
        F_COEFF_IM: rd_data_d = coeff_im_q[a_ch];
        F_POWER:    rd_data_d = W'(power_q[a_ch]);
        F_ACC_RE:   rd_data_d = acc_re_q[a_ch];
        F_ACC_IM:   rd_data_d = acc_im_q[a_ch];
        default:    rd_data_d = '0;
      endcase
    end
  end

  always_comb begin
    out_re = '0;
    out_im = '0;
    if (int'(out_sel) < NUM_CH) begin
      out_re = acc_re_q[out_sel];
      out_im = acc_im_q[out_sel];
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = (state_q == RUN);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_qosc_tdm_bank.sv
// Self-checking bench for qosc_tdm_bank with an arithmetic reference model
// (integer floor division by powers of two and explicit clamping).
module tb_qosc_tdm_bank;

  localparam int NUM_CH = 4;
  localparam int W      = 8;
  localparam int PW     = 4;
  localparam int CH_AW  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                refclk = 1'b0;
  logic                load = 1'b0;
  logic                wr_en = 1'b0;
  logic                clr_overrun = 1'b0;
  logic [CH_AW+2:0]    addr = '0;
  logic [W-1:0]        wr_data = '0;
  logic [W-1:0]        rd_data;
  logic [NUM_CH-1:0]   ch_en = '1;
  logic [CH_AW-1:0]    out_sel = '0;
  logic signed [W-1:0] out_re, out_im;
  logic                busy, frame_done, overrun;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  int m_init_re [NUM_CH];
  int m_init_im [NUM_CH];
  int m_coeff_re[NUM_CH];
  int m_coeff_im[NUM_CH];
  int m_power   [NUM_CH];
  int m_acc_re  [NUM_CH];
  int m_acc_im  [NUM_CH];

  qosc_tdm_bank #(.NUM_CH(NUM_CH), .W(W), .PW(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .refclk      (refclk),
    .load        (load),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .ch_en       (ch_en),
    .out_sel     (out_sel),
    .out_re      (out_re),
    .out_im      (out_im),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int sx(input int v);
    logic signed [7:0] b;
    b = v[7:0];
    return int'(b);
  endfunction

  function automatic int floor_pow2(input int p, input int s);
    int d;
    d = 1 << s;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_frame();
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_en[c]) begin
        int nr, ni;
        nr = clamp(floor_pow2(m_acc_re[c] * m_coeff_re[c] - m_acc_im[c] * m_coeff_im[c], m_power[c]));
        ni = clamp(floor_pow2(m_acc_re[c] * m_coeff_im[c] + m_acc_im[c] * m_coeff_re[c], m_power[c]));
        m_acc_re[c] = nr;
        m_acc_im[c] = ni;
      end
    end
  endtask

  task automatic model_load();
    for (int c = 0; c < NUM_CH; c++) begin
      m_acc_re[c] = m_init_re[c];
      m_acc_im[c] = m_init_im[c];
    end
  endtask

  // ---------------- drivers ----------------
  task automatic write_reg(input int ch, input int fld, input int val);
    @(negedge clk);
    addr    = {ch[CH_AW-1:0], fld[2:0]};
    wr_data = val[W-1:0];
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    case (fld)
      0: m_init_re[ch]  = sx(val);
      1: m_init_im[ch]  = sx(val);
      2: m_coeff_re[ch] = sx(val);
      3: m_coeff_im[ch] = sx(val);
      4: m_power[ch]    = val & 15;
      default: ;
    endcase
  endtask

  task automatic read_reg(input int ch, input int fld, output logic [W-1:0] v);
    @(negedge clk);
    addr  = {ch[CH_AW-1:0], fld[2:0]};
    wr_en = 1'b0;
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic do_load();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_load();
  endtask

  // One refclk rise; checks start latency, frame length and pulse width.
  task automatic run_frame();
    int n;
    @(negedge clk);
    refclk = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b1 || n > 3) begin
      errors++;
      $display("FAIL busy_latency: busy=%b after %0d cycles, required 1 within 3", busy, n);
    end
    n = 0;
    while (frame_done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1 || n != 4) begin
      errors++;
      $display("FAIL frame_len: frame_done=%b at %0d cycles after busy, required 1 at 4", frame_done, n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: busy=%b with frame_done, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_width: frame_done=%b second cycle, required 0", frame_done);
    end
    refclk = 1'b0;
    repeat (3) @(negedge clk);
    model_frame();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit saw_busy;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      refclk = ~refclk;
    end
    #1;
    checks++;
    if ({busy, frame_done, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/frame_done/overrun=%b, required 000", {busy, frame_done, overrun});
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rd_data: got %h, required 00", rd_data);
    end
    checks++;
    if (out_re !== 8'sd0 || out_im !== 8'sd0) begin
      errors++;
      $display("FAIL reset_out: got (%0d,%0d), required (0,0)", out_re, out_im);
    end
    refclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_busy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy) begin
      errors++;
      $display("FAIL idle_after_reset: busy seen without refclk rise, required none");
    end
    run_frame();
  endtask

  task automatic test_rotation();
    write_reg(0, 0, 64);
    write_reg(0, 1, 0);
    write_reg(0, 2, 0);
    write_reg(0, 3, 127);
    write_reg(0, 4, 7);
    do_load();
    run_frame();
    out_sel = 2'd0;
    #1;
    checks++;
    if (out_re !== 8'sd0 || out_im !== 8'sd63) begin
      errors++;
      $display("FAIL rot90_step1: got (%0d,%0d), required (0,63)", out_re, out_im);
    end
    run_frame();
    #1;
    checks++;
    if (out_re !== -8'sd63 || out_im !== 8'sd0) begin
      errors++;
      $display("FAIL rot90_step2: got (%0d,%0d), required (-63,0)", out_re, out_im);
    end
  endtask

  task automatic test_saturation();
    write_reg(1, 0, 127);
    write_reg(1, 1, 127);
    write_reg(1, 2, 127);
    write_reg(1, 3, 127);
    write_reg(1, 4, 0);
    do_load();
    run_frame();
    out_sel = 2'd1;
    #1;
    checks++;
    if (out_re !== 8'sd0 || out_im !== 8'sd127) begin
      errors++;
      $display("FAIL saturation: got (%0d,%0d), required (0,127)", out_re, out_im);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      out_sel = c[CH_AW-1:0];
      #1;
      checks++;
      if (out_re !== W'(m_acc_re[c]) || out_im !== W'(m_acc_im[c])) begin
        errors++;
        $display("FAIL sat_model ch%0d: got (%0d,%0d), required (%0d,%0d)", c, out_re, out_im, m_acc_re[c], m_acc_im[c]);
      end
    end
  endtask

  task automatic test_disabled();
    int fd0;
    logic [W-1:0] v;
    ch_en = 4'b1101;
    write_reg(1, 0, 10);
    write_reg(1, 1, 20);
    write_reg(1, 4, 0);
    do_load();
    fd0 = fd_count;
    repeat (3) run_frame();
    out_sel = 2'd1;
    #1;
    checks++;
    if (out_re !== 8'sd10 || out_im !== 8'sd20) begin
      errors++;
      $display("FAIL disabled_out: got (%0d,%0d), required (10,20)", out_re, out_im);
    end
    read_reg(1, 5, v);
    checks++;
    if (v !== 8'd10) begin
      errors++;
      $display("FAIL disabled_rd_re: got %0d, required 10", v);
    end
    read_reg(1, 6, v);
    checks++;
    if (v !== 8'd20) begin
      errors++;
      $display("FAIL disabled_rd_im: got %0d, required 20", v);
    end
    checks++;
    if (fd_count - fd0 != 3) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses, required 3", fd_count - fd0);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      out_sel = c[CH_AW-1:0];
      #1;
      checks++;
      if (out_re !== W'(m_acc_re[c]) || out_im !== W'(m_acc_im[c])) begin
        errors++;
        $display("FAIL disabled_model ch%0d: got (%0d,%0d), required (%0d,%0d)", c, out_re, out_im, m_acc_re[c], m_acc_im[c]);
      end
    end
    ch_en = 4'b1111;
  endtask

  task automatic test_readback();
    logic [W-1:0] v;
    int val;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int f = 0; f < 5; f++) begin
        val = (f == 4) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
        write_reg(c, f, val);
        read_reg(c, f, v);
        checks++;
        if (v !== val[W-1:0]) begin
          errors++;
          $display("FAIL readback ch%0d f%0d: got %h, required %h", c, f, v, val[W-1:0]);
        end
      end
    end
    // Same-cycle read and write returns the old value first.
    val = int'($urandom_range(0, 255));
    @(negedge clk);
    addr = {2'd2, 3'd2};
    wr_data = val[W-1:0];
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (rd_data !== W'(m_coeff_re[2])) begin
      errors++;
      $display("FAIL rd_old_value: got %h, required %h", rd_data, W'(m_coeff_re[2]));
    end
    m_coeff_re[2] = sx(val);
    @(negedge clk);
    checks++;
    if (rd_data !== val[W-1:0]) begin
      errors++;
      $display("FAIL rd_new_value: got %h, required %h", rd_data, val[W-1:0]);
    end
    do_load();
    write_reg(3, 5, 8'h5a);
    read_reg(3, 5, v);
    checks++;
    if (v !== W'(m_acc_re[3])) begin
      errors++;
      $display("FAIL acc_ro: got %h, required %h", v, W'(m_acc_re[3]));
    end
    read_reg(0, 7, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reserved_rd: got %h, required 00", v);
    end
  endtask

  task automatic overrun_frame(input bit pulse_clr, output int nb, output int nf, output logic ov_mid);
    nb = -1;
    nf = -1;
    ov_mid = 1'b0;
    @(negedge clk);
    refclk = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1 || k == 3) refclk = 1'b0;
      if (k == 2) refclk = 1'b1;
      if (k == 4 && pulse_clr) clr_overrun = 1'b1;
      if (k == 5) begin
        clr_overrun = 1'b0;
        ov_mid = overrun;
      end
      if (busy === 1'b1 && nb < 0) nb = k;
      if (frame_done === 1'b1 && nf < 0) nf = k;
    end
    model_frame();
  endtask

  task automatic test_overrun();
    int nb, nf;
    logic ov_mid;
    overrun_frame(1'b0, nb, nf, ov_mid);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    checks++;
    if (nb < 0 || nf - nb != 4) begin
      errors++;
      $display("FAIL overrun_frame_len: busy at %0d, frame_done at %0d, required 4 apart", nb, nf);
    end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    overrun_frame(1'b1, nb, nf, ov_mid);
    checks++;
    if (ov_mid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: mid=%b end=%b, required 1/1", ov_mid, overrun);
    end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_sel = c[CH_AW-1:0];
      #1;
      checks++;
      if (out_re !== W'(m_acc_re[c]) || out_im !== W'(m_acc_im[c])) begin
        errors++;
        $display("FAIL overrun_model ch%0d: got (%0d,%0d), required (%0d,%0d)", c, out_re, out_im, m_acc_re[c], m_acc_im[c]);
      end
    end
  endtask

  task automatic test_load_abort();
    int n, fd0;
    bit bad_busy;
    for (int c = 0; c < NUM_CH; c++) begin
      write_reg(c, 0, int'($urandom_range(0, 255)));
      write_reg(c, 1, int'($urandom_range(0, 255)));
      write_reg(c, 2, int'($urandom_range(1, 255)));
      write_reg(c, 3, int'($urandom_range(1, 255)));
      write_reg(c, 4, int'($urandom_range(0, 3)));
    end
    do_load();
    fd0 = fd_count;
    @(negedge clk);
    refclk = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b one cycle after load, required 0", busy);
    end
    refclk = 1'b0;
    bad_busy = 1'b0;
    repeat (3) @(negedge clk);
    refclk = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy === 1'b1) bad_busy = 1'b1;
    end
    refclk = 1'b0;
    repeat (4) @(negedge clk);
    load = 1'b0;
    model_load();
    repeat (4) begin
      @(negedge clk);
      if (busy === 1'b1) bad_busy = 1'b1;
    end
    checks++;
    if (bad_busy || overrun !== 1'b0) begin
      errors++;
      $display("FAIL load_ignores_tick: busy_seen=%b overrun=%b, required 0/0", bad_busy, overrun);
    end
    checks++;
    if (fd_count != fd0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d frame_done pulses, required 0", fd_count - fd0);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      out_sel = c[CH_AW-1:0];
      #1;
      checks++;
      if (out_re !== W'(m_init_re[c]) || out_im !== W'(m_init_im[c])) begin
        errors++;
        $display("FAIL abort_init ch%0d: got (%0d,%0d), required (%0d,%0d)", c, out_re, out_im, m_init_re[c], m_init_im[c]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int frames;
    for (int it = 0; it < 5; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int f = 0; f < 4; f++) write_reg(c, f, int'($urandom_range(0, 255)));
        write_reg(c, 4, int'($urandom_range(0, 15)));
      end
      ch_en = NUM_CH'($urandom_range(0, 15));
      do_load();
      frames = int'($urandom_range(1, 3));
      repeat (frames) run_frame();
      for (int c = 0; c < NUM_CH; c++) begin
        out_sel = c[CH_AW-1:0];
        #1;
        checks++;
        if (out_re !== W'(m_acc_re[c]) || out_im !== W'(m_acc_im[c])) begin
          errors++;
          $display("FAIL random_out it%0d ch%0d: got (%0d,%0d), required (%0d,%0d)", it, c, out_re, out_im, m_acc_re[c], m_acc_im[c]);
        end
        read_reg(c, 6, v);
        checks++;
        if (v !== W'(m_acc_im[c])) begin
          errors++;
          $display("FAIL random_rd_im it%0d ch%0d: got %h, required %h", it, c, v, W'(m_acc_im[c]));
        end
      end
    end
    ch_en = 4'b1111;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_saturation();
    test_disabled();
    test_readback();
    test_overrun();
    test_load_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
